uart_tx_sched: RTL and testbench
================================

# uart_tx_sched

Message-level scheduler that shares the single companion-MCU UART transmitter among several FPGA message sources, such as joypad reports, core-ID replies and config-string replies. It grants the transmitter to one requester at a time, round-robin, and holds the grant until that requester's last byte. This keeps every multi-byte message contiguous on the wire. It sits between the IO-system message generators and the `async_transmitter` instance, and a stall watchdog reclaims the transmitter from a hung source.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 65535: idle cycles allowed while granted before forced release (≥2).

Ports:
- `clk`, in, 1: main logic clock.
- `resetn`, in, 1: reset, synchronous, active-low; clock clk.
- `req`, in, NREQ: requester i wants the transmitter; must stay high until its last byte is accepted.
- `src_data`, in, 8*NREQ: byte of requester i in bits [8i+7:8i].
- `src_valid`, in, NREQ: byte of requester i is valid.
- `src_last`, in, NREQ: current byte is the final byte of the message.
- `src_ready`, out, NREQ: byte accepted when valid&ready (combinational).
- `grant`, out, NREQ: one-hot owner, all-zero when idle.
- `tx_data`, out, 8: byte to the UART transmitter.
- `tx_start`, out, 1: one-cycle start strobe.
- `tx_busy`, in, 1: transmitter busy.
- `timeout_err`, out, 1: one-cycle pulse on forced release.
- `timeout_src`, out, log2(NREQ) (min 1): index of the timed-out owner; held until the next timeout.

## Operation
- Reset values: `grant`=0, `tx_start`=0, `tx_data`=0, `src_ready`=0, `timeout_err`=0, `timeout_src`=0, round-robin pointer=0, state IDLE.
- IDLE: if any `req`, pick a winner by searching from pointer+1 cyclically (mod NREQ). Register `grant`, clear the watchdog and enter XFER. With no request, stay in IDLE.
- XFER, owner g:
  - `src_ready[g]` = ~tx_busy & ~tx_start; every other ready is 0.
  - On `src_valid[g]`&`src_ready[g]`: `tx_data`←`src_data[g]`, `tx_start`←1 for the next cycle only, and the watchdog is cleared.
  - If `src_last[g]` on the accepted byte: pointer←g, `grant`←0, go to IDLE.
- Abort: if `req[g]` drops in XFER before the last byte, `grant`←0, go to IDLE, pointer←g, no error. A byte accepted in that same cycle is still sent.
- Watchdog: in XFER, count cycles where ~tx_busy & ~tx_start and no byte is accepted. When the count reaches `TIMEOUT`: `timeout_err` pulses, `timeout_src`←g, pointer←g, `grant`←0, go to IDLE.
- Priority of simultaneous events in XFER: accepted last byte, then abort, then timeout.
- Unused or out-of-range requesters are never granted.
- A reset mid-message drops the grant immediately. A byte whose `tx_start` was already issued completes inside the transmitter.

## Timing
- `req` to `grant`: 1 cycle from IDLE.
- Accepted byte to `tx_start`: 1 cycle.
- `src_ready` is low during the `tx_start` cycle. This covers the transmitter asserting `tx_busy` one cycle late.
- After the last byte: 1 cycle in IDLE before the next grant. Message-to-message gap is therefore ≥1 idle cycle plus the UART busy time.
- Back-to-back requests from the same source re-arbitrate; any other pending source wins first.

## Structure
- Shared package `iosys_pkg`: UART message codes (JOYPAD=0x01, CORE_ID=0x11, CONFIG=0x22, NUL=0x00) and the default `BAUD_RATE`.
- Local to the module: the state encoding (IDLE, XFER).
- Sub-module `rr_pick`: combinational round-robin one-hot picker (inputs req and pointer, output one-hot winner and index), reusable elsewhere.

## Test plan
- Single source: NREQ=4, source 2 sends 5 bytes 01,AA,BB,CC,DD with last on DD → `grant`=0100 one cycle after `req`; `tx_start` pulses 5×, each after `tx_busy` falls; `grant`=0 after DD.
- Contention: sources 0, 1 and 3 request together with pointer=0 → service order 1,3,0. Messages are never interleaved, with a 1-cycle IDLE gap between them.
- Fairness: source 0 re-requests immediately while source 1 is pending → source 1 is granted before source 0's second message.
- Timeout, TIMEOUT=16: owner 3 holds `req` with `src_valid`=0 → after 16 counted cycles `timeout_err` is one pulse, `timeout_src`=3, `grant`=0, and the next requester is granted.
- Abort and reset: the owner drops `req` after 2 of 4 bytes → release with no error. `resetn` low mid-message → `grant`=0, `tx_start`=0 next cycle, and the pointer returns to 0.

Source files
------------

// File: rtl/iosys_pkg.sv
// Shared IO-system definitions: UART message codes, default baud rate and a
// width helper used by the message schedulers.
package iosys_pkg;

    localparam logic [7:0] MSG_NUL     = 8'h00;
    localparam logic [7:0] MSG_JOYPAD  = 8'h01;
    localparam logic [7:0] MSG_CORE_ID = 8'h11;
    localparam logic [7:0] MSG_CONFIG  = 8'h22;

    localparam int BAUD_RATE = 115200;

    // Width of an index into n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: the winner is the first requester found
// when searching cyclically from ptr+1, so the last owner has lowest priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    int cand;

    // Cyclic search starting just after the pointer; first hit wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                win[cand] = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Message-level scheduler sharing one UART transmitter among NREQ sources.
// The grant is held for a whole message so multi-byte messages stay
// contiguous; a watchdog reclaims the transmitter from a stalled owner.
//
// Byte handshake: a byte of the owner is accepted in a cycle where both
// src_valid and src_ready are high at the rising clock edge; src_ready is
// combinational and only ever high for the current owner while the
// transmitter is free (not busy and no start strobe in flight).
module uart_tx_sched
    import iosys_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535,
    localparam int IW     = idx_width(NREQ)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] src_data,
    input  logic [NREQ-1:0]   src_valid,
    input  logic [NREQ-1:0]   src_last,
    output logic [NREQ-1:0]   src_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              timeout_err,
    output logic [IW-1:0]     timeout_src
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [WW-1:0]   wd_cnt;

    logic [NREQ-1:0] pick_win;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    logic            slot_free;
    logic            accept;
    logic            wd_tick;
    logic [7:0]      owner_byte;
    logic            owner_req;
    logic            owner_last;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // tx_start counts as busy: the transmitter raises tx_busy a cycle late.
    assign slot_free = ~tx_busy & ~tx_start;
    assign src_ready = (state == XFER && slot_free) ? grant : '0;
    assign accept    = |(src_valid & src_ready);
    assign wd_tick   = slot_free & ~accept;

    // Select the owner's byte, request and last flag.
    always_comb begin
        owner_byte = '0;
        owner_req  = 1'b0;
        owner_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                owner_byte = src_data[8*i +: 8];
                owner_req  = req[i];
                owner_last = src_last[i];
            end
        end
    end

    // Arbitration / transfer FSM with registered grant, strobe and watchdog.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            grant       <= '0;
            owner       <= '0;
            ptr         <= '0;
            wd_cnt      <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            timeout_src <= '0;
        end else begin
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant  <= pick_win;
                        owner  <= pick_idx;
                        wd_cnt <= '0;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    // An accepted byte is always sent, even on abort.
                    if (accept) begin
                        tx_data  <= owner_byte;
                        tx_start <= 1'b1;
                        wd_cnt   <= '0;
                    end
                    if (accept && owner_last) begin
                        ptr   <= owner;
                        grant <= '0;
                        state <= IDLE;
                    end else if (!owner_req) begin
                        ptr   <= owner;
                        grant <= '0;
                        state <= IDLE;
                    end else if (wd_tick && wd_cnt == WD_LAST) begin
                        ptr         <= owner;
                        grant       <= '0;
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        timeout_src <= owner;
                    end else if (wd_tick) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: randomized message traffic against a message-level
// round-robin model, plus directed timeout, abort and mid-message reset cases.
module tb_uart_tx_sched;
    import iosys_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int IW      = 2;

    logic              clk;
    logic              resetn;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] src_data;
    logic [NREQ-1:0]   src_valid;
    logic [NREQ-1:0]   src_last;
    logic [NREQ-1:0]   src_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              timeout_err;
    logic [IW-1:0]     timeout_src;

    uart_tx_sched #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req         (req),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .grant       (grant),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err),
        .timeout_src (timeout_src)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- stimulus store and reference model ----------------
    logic [7:0] byte_q[NREQ][$];
    int         len_q[NREQ][$];
    int         abort_n[NREQ];
    bit         kill[NREQ];

    logic [7:0] exp_q[$];
    int         exp_owner[$];
    int         model_ptr;

    task automatic add_msg(input int i, input int n);
        for (int b = 0; b < n; b++) byte_q[i].push_back(8'($urandom_range(0, 255)));
        len_q[i].push_back(n);
    endtask

    // Message-level round robin: every loaded source requests from the start
    // and keeps requesting while it has messages; the next owner is the first
    // pending source after the previous owner.
    task automatic model_run();
        int li[NREQ];
        int bi[NREQ];
        int found, c, n, sent;
        for (int i = 0; i < NREQ; i++) begin li[i] = 0; bi[i] = 0; end
        forever begin
            found = -1;
            for (int k = 1; k <= NREQ; k++) begin
                c = (model_ptr + k) % NREQ;
                if (found < 0 && li[c] < len_q[c].size()) found = c;
            end
            if (found < 0) break;
            n    = len_q[found][li[found]];
            sent = n;
            if (li[found] == 0 && abort_n[found] > 0 && abort_n[found] < n) sent = abort_n[found];
            exp_owner.push_back(found);
            for (int b = 0; b < n; b++) begin
                if (b < sent) exp_q.push_back(byte_q[found][bi[found]]);
                bi[found]++;
            end
            li[found]++;
            model_ptr = found;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic src_run(input int i);
        int n, guard;
        logic [7:0] d;
        bit acc, first;
        first = 1;
        @(negedge clk);
        while (len_q[i].size() > 0 && !kill[i]) begin
            n = len_q[i].pop_front();
            req[i] = 1'b1;
            for (int b = 0; b < n && !kill[i]; b++) begin
                d = byte_q[i].pop_front();
                if (first && abort_n[i] > 0 && b == abort_n[i]) begin
                    req[i] = 1'b0; src_valid[i] = 1'b0; src_last[i] = 1'b0;
                    for (int r = b + 1; r < n; r++) d = byte_q[i].pop_front();
                    break;
                end
                if ($urandom_range(0, 3) == 0) begin
                    src_valid[i] = 1'b0;
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                end
                src_valid[i] = 1'b1;
                src_data[8*i +: 8] = d;
                src_last[i] = (b == n - 1);
                acc = 0; guard = 0;
                while (!acc && !kill[i]) begin
                    #4;
                    acc = src_valid[i] & src_ready[i];
                    @(negedge clk);
                    guard++;
                    if (guard > 300) begin
                        check("src_stall_cycles", guard, 300);
                        kill[i] = 1;
                    end
                end
                src_valid[i] = 1'b0;
                src_last[i]  = 1'b0;
            end
            first = 0;
        end
        req[i] = 1'b0; src_valid[i] = 1'b0; src_last[i] = 1'b0;
    endtask

    task automatic run_all();
        fork
            src_run(0);
            src_run(1);
            src_run(2);
            src_run(3);
        join
    endtask

    task automatic wait_quiet();
        int q;
        q = 0;
        for (int c = 0; c < 2000 && q < 4; c++) begin
            @(posedge clk); #1;
            if (!tx_busy && !tx_start && grant == '0 && req == '0) q++;
            else q = 0;
        end
        check("quiet", q, 4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_ptr = 0;
    endtask

    // ---------------- transmitter model: busy rises one cycle late ----------------
    initial begin
        int cnt;
        cnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            tx_busy = (cnt > 0);
            if (cnt > 0) cnt--;
            if (tx_start) cnt = $urandom_range(2, 5);
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [NREQ-1:0] prev_grant;
    int n_starts;
    int n_timeouts;
    bit mon_on;

    initial begin
        prev_grant = '0;
        n_starts   = 0;
        n_timeouts = 0;
        forever begin
            @(posedge clk); #1;
            if (mon_on) begin
                if (tx_start) begin
                    n_starts++;
                    check("ready_in_start", src_ready, '0);
                    check("byte_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("tx_byte", tx_data, exp_q.pop_front());
                end
                if (timeout_err) n_timeouts++;
                if (grant != prev_grant) begin
                    check("idle_gap", (prev_grant == '0 || grant == '0), 1);
                    if (grant != '0) begin
                        check("owner_pending", exp_owner.size() > 0, 1);
                        if (exp_owner.size() > 0)
                            check("owner", grant, NREQ'(1) << exp_owner.pop_front());
                    end
                end
            end
            prev_grant = grant;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] p1[5];
        int s0, t0;
        p1 = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        mon_on = 0;
        resetn = 1'b0;
        req = '0; src_valid = '0; src_last = '0; src_data = '0;
        for (int i = 0; i < NREQ; i++) begin abort_n[i] = 0; kill[i] = 0; end

        // Reset values
        repeat (3) @(posedge clk); #1;
        check("rst_grant", grant, '0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_src_ready", src_ready, '0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_timeout_src", timeout_src, 0);
        @(negedge clk);
        resetn = 1'b1;
        model_ptr = 0;
        mon_on = 1;

        // Single source: 5-byte message from source 2
        foreach (p1[k]) byte_q[2].push_back(p1[k]);
        len_q[2].push_back(5);
        model_run();
        s0 = n_starts;
        fork
            src_run(2);
            begin
                @(negedge clk);
                @(posedge clk); #1;
                check("req_to_grant", grant, 4'b0100);
            end
        join
        wait_quiet();
        check("single_starts", n_starts - s0, 5);
        check("single_grant_idle", grant, '0);

        // Contention from pointer 0: expected order 1,3,0
        do_reset();
        add_msg(0, $urandom_range(2, 4));
        add_msg(1, $urandom_range(2, 4));
        add_msg(3, $urandom_range(2, 4));
        model_run();
        run_all();
        wait_quiet();

        // Fairness: set pointer to 3, then source 0 (two messages) vs source 1
        add_msg(3, 2);
        model_run();
        run_all();
        wait_quiet();
        add_msg(0, 3);
        add_msg(0, 2);
        add_msg(1, 3);
        model_run();
        run_all();
        wait_quiet();

        // Watchdog: source 3 holds req without data, source 1 waits
        t0 = n_timeouts;
        @(negedge clk);
        req[3] = 1'b1;
        exp_owner.push_back(3);
        @(posedge clk); #1;
        check("to_grant", grant, 4'b1000);
        model_ptr = 3;
        add_msg(1, 3);
        model_run();
        fork
            src_run(1);
            begin
                repeat (TIMEOUT - 1) @(posedge clk);
                #1;
                check("to_early_err", timeout_err, 0);
                check("to_early_grant", grant, 4'b1000);
                @(posedge clk); #1;
                check("to_err", timeout_err, 1);
                check("to_src", timeout_src, 3);
                check("to_release", grant, '0);
                req[3] = 1'b0;
                @(posedge clk); #1;
                check("to_pulse", timeout_err, 0);
                check("to_next_grant", grant, 4'b0010);
            end
        join
        wait_quiet();
        check("to_count", n_timeouts - t0, 1);

        // Abort: source 2 drops req after 2 of 4 bytes, source 0 waiting
        t0 = n_timeouts;
        abort_n[2] = 2;
        add_msg(2, 4);
        add_msg(0, 3);
        model_run();
        run_all();
        abort_n[2] = 0;
        wait_quiet();
        check("abort_no_err", n_timeouts - t0, 0);

        // Reset mid-message: pointer at 3 first, then reset while source 2 sends
        add_msg(3, 2);
        model_run();
        run_all();
        wait_quiet();
        add_msg(2, 6);
        exp_owner.push_back(2);
        exp_q.push_back(byte_q[2][0]);
        exp_q.push_back(byte_q[2][1]);
        s0 = n_starts;
        fork
            src_run(2);
            begin
                for (int c = 0; c < 500 && (n_starts - s0) < 2; c++) @(negedge clk);
                check("rst_wait_starts", n_starts - s0, 2);
                resetn = 1'b0;
                kill[2] = 1;
                @(posedge clk); #1;
                check("midrst_grant", grant, '0);
                check("midrst_tx_start", tx_start, 0);
                check("midrst_ready", src_ready, '0);
                check("midrst_timeout_src", timeout_src, 0);
                @(negedge clk);
                resetn = 1'b1;
            end
        join
        byte_q[2].delete();
        len_q[2].delete();
        kill[2] = 0;
        model_ptr = 0;
        wait_quiet();
        // Pointer back at 0: source 3 must win over source 0
        add_msg(0, 2);
        add_msg(3, 2);
        model_run();
        run_all();
        wait_quiet();

        // Randomized traffic
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREQ; i++)
                repeat ($urandom_range(0, 2)) add_msg(i, $urandom_range(1, 4));
            model_run();
            run_all();
            wait_quiet();
        end

        check("exp_bytes_drained", exp_q.size(), 0);
        check("exp_owners_drained", exp_owner.size(), 0);
        check("timeouts_total", n_timeouts, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
